ahb_master_ctrl: RTL
====================

// Module: ahb_master_ctrl
// PURPOSE
// - AHB-Lite initiator for the FPGA test rig; drives the bus that feeds the two 8-bit ahbslave instances.
// - Turns one command (captured on a start pulse) into a SINGLE or INCR4 transfer on that bus.
// - Decodes the slave select, honours wait states and the two-cycle ERROR response, and returns read data and status.
// PARAMETERS
// - AW  10  address width (1 KB space)
// - DW  8   data width
// PORTS
// - hclk         in   1   bus clock
// - hreset       in   1   asynchronous, active-high reset
// - start        in   1   1-cycle command strobe; sampled only in IDLE, ignored while busy
// - cmd_write    in   1   1 = write, 0 = read
// - cmd_slave    in   1   0 = slave 1, 1 = slave 2
// - cmd_burst    in   1   0 = SINGLE, 1 = INCR4
// - cmd_addr     in   AW  start address
// - cmd_wdata    in   DW  write data for beat 0; beat n carries cmd_wdata+n (mod 256)
// - hreadyout_1  in   1   slave 1 ready
// - hreadyout_2  in   1   slave 2 ready
// - hresp_1      in   1   slave 1 response (1 = ERROR)
// - hresp_2      in   1   slave 2 response
// - hrdata_1     in   DW  slave 1 read data
// - hrdata_2     in   DW  slave 2 read data
// - hsel_1       out  1   slave 1 select
// - hsel_2       out  1   slave 2 select
// - haddr        out  AW  address-phase address
// - hwrite       out  1   address-phase direction
// - hburst       out  3   000 SINGLE, 011 INCR4
// - htrans       out  2   00 IDLE, 10 NONSEQ, 11 SEQ
// - hwdata       out  DW  data-phase write data
// - busy         out  1   command in progress
// - done         out  1   1-cycle pulse at command end
// - error        out  1   last command failed; held until the next accepted start
// - rd_data      out  DW  data from the last completed read beat
// BEHAVIOUR
// - Reset (async, immediate): FSM to IDLE; every output 0 (htrans=IDLE, hsel_*=0).
//   Reset mid-burst abandons the transfer with no completion.
// - Captured command is held in registers; cmd_* inputs may change after start.
// - Bus hready = selected slave's hreadyout; bus hresp = selected slave's hresp.
// - FSM states: IDLE, ADDR, DATA_LAST, ERR, DONE.
// - IDLE
//   - start, with cmd_burst=1 and cmd_addr>1020 (burst would cross the 1 KB boundary):
//     no bus activity; DONE with error=1.
//   - Otherwise start -> ADDR: busy=1, error cleared, selected hsel driven.
// - ADDR: drives htrans/haddr/hwrite/hburst for beat n (beat 0 NONSEQ, later beats SEQ).
//   - All address-phase signals are held while hready=0.
//   - When hready=1: haddr+1 for the next beat, and hwdata takes that beat's data in the next cycle.
//   - After the last beat is accepted -> DATA_LAST with htrans=IDLE.
// - Pipelining: the data phase of beat n overlaps the address phase of beat n+1.
//   - Reads capture rd_data when hready=1 in the data phase.
// - DATA_LAST: wait for hready=1 on the final data phase -> DONE.
// - Error: hresp=1 && hready=0 in any data phase -> ERR.
//   - Next cycle: htrans=IDLE, pending beats cancelled.
//   - hready=1 on the 2nd response cycle -> DONE with error=1.
// - DONE: done=1 for one cycle, busy=0, hsel_* released -> IDLE. A start in DONE is ignored.
// - Latency, zero wait states:
//   - SINGLE: start at cycle 0, address phase cycle 1, data phase cycle 2, done cycle 3.
//   - INCR4: done at cycle 6.
// - Each wait-state cycle adds one cycle to the total.
// - hsel stays asserted from the first address phase through the final data phase. Only one hsel is ever high.
// - Address and data arithmetic wraps modulo 2^AW and 2^DW.
// TESTING
// - SINGLE write, slave 1, addr 0x005, data 0xA5, ready=1
//   -> c1: NONSEQ, haddr=0x005, hwrite=1, hsel_1=1. c2: hwdata=0xA5. c3: done=1, error=0.
// - INCR4 read, slave 2, addr 0x010, hrdata=0x40..0x43
//   -> haddr 0x010..0x013 with NONSEQ,SEQ,SEQ,SEQ; hburst=011; hsel_2 only; rd_data=0x43; done at c6.
// - INCR4 write with hreadyout_1=0 for 2 cycles during beat 1 data
//   -> haddr/htrans/hwdata frozen; hwdata sequence A5,A6,A7,A8; done at c8.
// - INCR4 read with hresp_2=1 for 2 cycles on beat 1 (hready 0 then 1)
//   -> htrans=IDLE in the cycle after the 1st ERROR cycle; no further beats; done=1, error=1.
// - INCR4 at addr 0x3FE -> no htrans activity; done=1, error=1 one cycle after start.
// - hreset=1 mid-burst at beat 2 -> same-cycle htrans=0, hsel_*=0, busy=0; next start runs normally.

Source files
------------

// File: rtl/ahb_master_ctrl.sv
// ahb_master_ctrl
// AHB-Lite initiator for the FPGA test rig. A single command is captured on a
// start pulse and turned into a SINGLE or INCR4 transfer towards one of two
// 8-bit slaves. The controller decodes the slave select, honours wait states,
// handles the two-cycle ERROR response, and reports read data and status.
// Address and data phases are pipelined: the data phase of beat n overlaps
// the address phase of beat n+1.

module ahb_master_ctrl #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          start,
    input  logic          cmd_write,
    input  logic          cmd_slave,
    input  logic          cmd_burst,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic          hreadyout_1,
    input  logic          hreadyout_2,
    input  logic          hresp_1,
    input  logic          hresp_2,
    input  logic [DW-1:0] hrdata_1,
    input  logic [DW-1:0] hrdata_2,
    output logic          hsel_1,
    output logic          hsel_2,
    output logic [AW-1:0] haddr,
    output logic          hwrite,
    output logic [2:0]    hburst,
    output logic [1:0]    htrans,
    output logic [DW-1:0] hwdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA_LAST,
        ERR,
        DONE
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    // Highest start address from which four incrementing beats still fit
    // below the top of the address space (1020 for a 1 KB space).
    localparam logic [AW-1:0] BURST_ADDR_MAX = ~AW'(3);

    state_t        state_q;
    state_t        state_d;

    // Captured command
    logic          write_q;
    logic          slave_q;
    logic          burst_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // Beat tracking
    logic [1:0]    beat_q;
    logic [1:0]    last_beat;
    logic          data_pending_q;

    // Result registers
    logic [DW-1:0] hwdata_q;
    logic [DW-1:0] rd_data_q;
    logic          error_q;

    // Bus view of the selected slave
    logic          hready_bus;
    logic          hresp_bus;
    logic [DW-1:0] hrdata_bus;

    // Cycle classification and strobes
    logic          data_phase;
    logic          err_now;
    logic          burst_cross;
    logic          cmd_load;
    logic          cmd_reject;
    logic          beat_accept;
    logic          read_capture;
    logic          fail_done;

    // Only the slave addressed by the current command talks back to us, so
    // its handshake and read data become the bus view.
    always_comb begin
        hready_bus = hreadyout_1;
        hresp_bus  = hresp_1;
        hrdata_bus = hrdata_1;
        if (slave_q) begin
            hready_bus = hreadyout_2;
            hresp_bus  = hresp_2;
            hrdata_bus = hrdata_2;
        end
    end

    // A data phase is in flight once the first beat's address has been
    // accepted; an ERROR only counts on its first (not-ready) cycle.
    always_comb begin
        data_phase  = ((state_q == ADDR) && data_pending_q) || (state_q == DATA_LAST);
        err_now     = data_phase && hresp_bus && !hready_bus;
        last_beat   = burst_q ? 2'd3 : 2'd0;
        burst_cross = cmd_burst && (cmd_addr > BURST_ADDR_MAX);
    end

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_d      = state_q;
        cmd_load     = 1'b0;
        cmd_reject   = 1'b0;
        beat_accept  = 1'b0;
        read_capture = 1'b0;
        fail_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_cross) begin
                        cmd_reject = 1'b1;
                        state_d    = DONE;
                    end else begin
                        cmd_load = 1'b1;
                        state_d  = ADDR;
                    end
                end
            end
            ADDR: begin
                if (err_now) begin
                    state_d = ERR;
                end else if (hready_bus) begin
                    beat_accept  = 1'b1;
                    read_capture = data_pending_q && !write_q;
                    if (beat_q == last_beat) begin
                        state_d = DATA_LAST;
                    end
                end
            end
            DATA_LAST: begin
                if (err_now) begin
                    state_d = ERR;
                end else if (hready_bus) begin
                    read_capture = !write_q;
                    state_d      = DONE;
                end
            end
            ERR: begin
                if (hready_bus) begin
                    fail_done = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hold the command once accepted so the cmd_* inputs are free to change.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            write_q <= 1'b0;
            slave_q <= 1'b0;
            burst_q <= 1'b0;
            wdata_q <= '0;
        end else if (cmd_load) begin
            write_q <= cmd_write;
            slave_q <= cmd_slave;
            burst_q <= cmd_burst;
            wdata_q <= cmd_wdata;
        end
    end

    // Advance address and beat count as each address phase is accepted; the
    // final beat leaves them alone since no further address phase follows.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr_q         <= '0;
            beat_q         <= 2'd0;
            data_pending_q <= 1'b0;
        end else if (cmd_load) begin
            addr_q         <= cmd_addr;
            beat_q         <= 2'd0;
            data_pending_q <= 1'b0;
        end else if (beat_accept) begin
            data_pending_q <= 1'b1;
            if (beat_q != last_beat) begin
                addr_q <= addr_q + AW'(1);
                beat_q <= beat_q + 2'd1;
            end
        end
    end

    // Write data for a beat appears in the cycle after its address is taken
    // and stays put through any wait states of that data phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hwdata_q <= '0;
        end else if (beat_accept) begin
            hwdata_q <= wdata_q + DW'(beat_q);
        end
    end

    // Latch read data whenever a read data phase completes without error.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rd_data_q <= '0;
        end else if (read_capture) begin
            rd_data_q <= hrdata_bus;
        end
    end

    // Error status is sticky until the next accepted command clears it.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            error_q <= 1'b0;
        end else if (cmd_reject || fail_done) begin
            error_q <= 1'b1;
        end else if (cmd_load) begin
            error_q <= 1'b0;
        end
    end

    // Bus outputs decode straight from state so a reset clears them at once.
    always_comb begin
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hburst = HBURST_SINGLE;
        if (state_q == ADDR) begin
            htrans = (beat_q == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            hwrite = write_q;
            hburst = burst_q ? HBURST_INCR4 : HBURST_SINGLE;
        end
        busy    = (state_q == ADDR) || (state_q == DATA_LAST) || (state_q == ERR);
        hsel_1  = busy && !slave_q;
        hsel_2  = busy && slave_q;
        done    = (state_q == DONE);
        haddr   = addr_q;
        hwdata  = hwdata_q;
        error   = error_q;
        rd_data = rd_data_q;
    end

endmodule
